// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg -- shared types and constants for the fetch/data memory arbiter.
//   DATA_W             : width of address and data paths
//   STARVE_W           : width of the fetch starvation counter (covers 1..15)
//   STARVE_MAX_DEFAULT : default stalled-fetch limit before fetch is forced
//   t_rsp_owner        : which requester owns the response presented next cycle
package mem_arb_pkg;

    localparam int DATA_W             = 32;
    localparam int STARVE_W           = 4;
    localparam int STARVE_MAX_DEFAULT = 4;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } t_rsp_owner;

endpackage

// File: rtl/mem_arb.sv
// mem_arb -- arbitrates one shared single-port memory between an instruction
// fetch requester and a load/store data requester. One access is granted per
// cycle, data wins by default, and fetch is forced through after STARVE_MAX
// consecutive stalled cycles. Read data returns exactly one cycle after the
// grant and is steered to whichever requester issued the read.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   i_req_valid/addr, i_req_ready  fetch request handshake
//   i_rsp_valid/data               fetch read response
//   d_req_valid/addr/wr_en/wr_data/byte_en/is_signed, d_req_ready
//                                  data request handshake (ready = store done)
//   d_rsp_valid/data               load response
//   mem_addr/wr_data/wr_en/byte_en/is_signed  request to memory wrapper
//   mem_rd_data                    memory wrapper read data (1-cycle latency)
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_req_valid,
    input  logic [DATA_W-1:0] i_req_addr,
    output logic              i_req_ready,
    output logic              i_rsp_valid,
    output logic [DATA_W-1:0] i_rsp_data,

    input  logic              d_req_valid,
    input  logic [DATA_W-1:0] d_req_addr,
    input  logic              d_req_wr_en,
    input  logic [DATA_W-1:0] d_req_wr_data,
    input  logic [3:0]        d_req_byte_en,
    input  logic              d_req_is_signed,
    output logic              d_req_ready,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rsp_data,

    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_wr_en,
    output logic              mem_is_signed,
    output logic [3:0]        mem_byte_en,
    input  logic [DATA_W-1:0] mem_rd_data
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] starve_cnt_p1;
    t_rsp_owner          rsp_owner_p1;

    logic starved;
    logic fetch_gnt;
    logic data_gnt;

    // ---- stage p0: combinational grant and memory request ----
    // Reset masks both grants so nothing (in particular no store) reaches
    // memory while rst is high.
    always_comb begin
        starved   = (starve_cnt_p1 == STARVE_LIM);
        fetch_gnt = !rst && i_req_valid && (!d_req_valid || starved);
        data_gnt  = !rst && d_req_valid && !fetch_gnt;
    end

    assign i_req_ready = fetch_gnt;
    assign d_req_ready = data_gnt;

    always_comb begin
        mem_addr      = '0;
        mem_wr_data   = '0;
        mem_wr_en     = 1'b0;
        mem_byte_en   = 4'b0000;
        mem_is_signed = 1'b0;
        if (fetch_gnt) begin
            mem_addr    = i_req_addr;
            mem_byte_en = 4'b1111;
        end else if (data_gnt) begin
            mem_addr      = d_req_addr;
            mem_wr_data   = d_req_wr_data;
            mem_wr_en     = d_req_wr_en;
            mem_byte_en   = d_req_byte_en;
            mem_is_signed = d_req_is_signed;
        end
    end

    // ---- stage p1: starvation count and response owner ----
    // The counter only advances while fetch is waiting behind a data grant;
    // any cycle without a fetch request, or any fetch grant, restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_p1 <= '0;
            rsp_owner_p1  <= NONE;
        end else begin
            if (!i_req_valid || fetch_gnt) begin
                starve_cnt_p1 <= '0;
            end else if (data_gnt && !starved) begin
                starve_cnt_p1 <= starve_cnt_p1 + 1'b1;
            end

            if (fetch_gnt) begin
                rsp_owner_p1 <= FETCH;
            end else if (data_gnt && !d_req_wr_en) begin
                rsp_owner_p1 <= DATA;
            end else begin
                rsp_owner_p1 <= NONE;
            end
        end
    end

    // Gating with rst drops a response that was in flight when reset hit.
    assign i_rsp_valid = !rst && (rsp_owner_p1 == FETCH);
    assign d_rsp_valid = !rst && (rsp_owner_p1 == DATA);
    assign i_rsp_data  = i_rsp_valid ? mem_rd_data : '0;
    assign d_rsp_data  = d_rsp_valid ? mem_rd_data : '0;

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter STARVE_MAX, default 4: consecutive stalled fetch cycles before fetch is force-granted; legal range 1..15.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 i_req_valid  input  1  fetch requester has a word read pending.
REQ-005 i_req_addr  input  32  fetch byte address.
REQ-006 i_req_ready  output  1  fetch request accepted this cycle.
REQ-007 i_rsp_valid  output  1  fetch read data valid.
REQ-008 i_rsp_data  output  32  fetch read data.
REQ-009 d_req_valid  input  1  data requester has a load/store pending.
REQ-010 d_req_addr  input  32  data byte address.
REQ-011 d_req_wr_en  input  1  1=store, 0=load.
REQ-012 d_req_wr_data  input  32  store data, LSB-aligned.
REQ-013 d_req_byte_en  input  4  0001 byte, 0011 halfword, 1111 word.
REQ-014 d_req_is_signed  input  1  load sign-extend select.
REQ-015 d_req_ready  output  1  data request accepted this cycle; for stores, completion.
REQ-016 d_rsp_valid  output  1  load data valid.
REQ-017 d_rsp_data  output  32  load data.
REQ-018 mem_addr, mem_wr_data  output  32 each  to memory wrapper.
REQ-019 mem_wr_en, mem_is_signed  output  1 each; mem_byte_en  output  4  to memory wrapper.
REQ-020 mem_rd_data  input  32  memory wrapper read data, valid one cycle after address issue.

Function
REQ-021 At most one request shall be granted per cycle; grant is combinational from valids and starvation count; a request is accepted when valid && ready.
REQ-022 Default priority: data over fetch.
REQ-023 Starvation counter shall increment each cycle i_req_valid=1 and the data request is granted; it saturates at STARVE_MAX.
REQ-024 When counter == STARVE_MAX and i_req_valid=1, fetch shall be granted regardless of d_req_valid; counter clears to 0 on every fetch grant or any cycle i_req_valid=0.
REQ-025 Fetch grant drives mem_addr=i_req_addr, mem_byte_en=1111, mem_wr_en=0, mem_is_signed=0.
REQ-026 Data grant drives mem_* from d_req_* fields unmodified.
REQ-027 No grant: mem_wr_en=0, mem_byte_en=0000, mem_addr=0, mem_wr_data=0, mem_is_signed=0.
REQ-028 Response owner register (NONE/FETCH/DATA) shall load FETCH on fetch grant, DATA on data-load grant, NONE otherwise (including stores).
REQ-029 i_rsp_valid = (owner==FETCH); d_rsp_valid = (owner==DATA); *_rsp_data = mem_rd_data when valid, 0 otherwise; latency exactly 1 cycle after acceptance.
REQ-030 Back-to-back grants shall be supported: new grant in the same cycle a previous response is presented, sustaining one access per cycle.
REQ-031 Stores produce no response; no response backpressure exists, requesters always sink responses.
REQ-032 Requesters hold request fields stable while valid && !ready; arbiter need not check.

Reset
REQ-033 While rst=1: i_req_ready=0, d_req_ready=0, mem_wr_en=0, mem_byte_en=0000; no store reaches memory.
REQ-034 After a rst cycle: owner=NONE, counter=0, i_rsp_valid=0, d_rsp_valid=0; a response pending at reset is dropped.

Structure
REQ-035 Package mem_arb_pkg shall hold typedef enum t_rsp_owner {NONE, FETCH, DATA} and the default STARVE_MAX constant.
REQ-036 Single flat module, no sub-modules; memory wrapper instantiated by the parent, not inside mem_arb.

Verification
REQ-037 Fetch only: i_req_valid=1, addr 0x10 -> i_req_ready same cycle, i_rsp_valid next cycle with word at 0x10.
REQ-038 Simultaneous: i/d valid, d load byte signed at 0x03 holding 0x80 -> d granted, d_rsp_data=0xFFFFFF80 next cycle, i_req_ready=0.
REQ-039 Starvation: STARVE_MAX=4, both valid continuously -> 4 data grants, then 1 fetch grant in 5th cycle, pattern repeats.
REQ-040 Store then load: d store halfword 0xBEEF at 0x22, then load unsigned halfword 0x22 -> no d_rsp_valid for store, 0x0000BEEF on load.
REQ-041 Reset mid-operation: fetch accepted, rst asserted next cycle -> i_rsp_valid=0 throughout, owner NONE, counter 0 after reset.
REQ-042 Store during rst=1 -> mem_wr_en stays 0, memory contents unchanged.
